// File: rtl/neuron_pkg.sv
// neuron_pkg: shared widths and MAC state encoding for the neuron datapath stages.
package neuron_pkg;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} mac_state_t;
endpackage

// File: rtl/neuron_mul.sv
// neuron_mul: registered signed DATA_W x DATA_W multiplier with valid tracking.
module neuron_mul #(
    parameter int DATA_W = neuron_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_W-1:0]     a_i,
    input  logic signed [DATA_W-1:0]     b_i,
    input  logic                         vld_i,
    output logic signed [2*DATA_W-1:0]   p_q,
    output logic                         p_vld_q
);
    logic signed [2*DATA_W-1:0] p_d;

    assign p_d = vld_i ? a_i * b_i : p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= '0;
            p_vld_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            p_vld_q <= vld_i;
        end
    end
endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: streaming signed MAC for one neuron; define NEURON_MAC_SAT_EN to
// saturate the accumulator on overflow instead of wrapping.
module neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = neuron_pkg::DATA_W,
    parameter int ACC_W    = neuron_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     ovf
);
    import neuron_pkg::*;

    mac_state_t                 state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d, p_ext, sum, acc_nxt;
    logic                       ovf_q, ovf_d, ovf_now, beat, p_vld;
    logic signed [2*DATA_W-1:0] p_q;

    assign beat = in_valid && (state_q == ACCUM);

    neuron_mul #(.DATA_W(DATA_W)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_i    (x_in),
        .b_i    (w_in),
        .vld_i  (beat),
        .p_q    (p_q),
        .p_vld_q(p_vld)
    );

    assign p_ext   = ACC_W'(p_q);
    assign sum     = acc_q + p_ext;
    assign ovf_now = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef NEURON_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    assign acc_nxt = ovf_now ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum;
`else
    assign acc_nxt = sum;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = p_vld ? acc_nxt : acc_q;
        ovf_d     = ovf_q | (p_vld & ovf_now);
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCUM;
                cnt_d   = '0;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = (cnt_q == 8'(N_INPUTS - 1)) ? DRAIN : ACCUM;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                state_d   = out_ready ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_out = acc_q;
    assign busy    = state_q != IDLE;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed self-checking bench for neuron_mac.
module tb_neuron_mac;
    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic signed [7:0] x_in = '0;
    logic signed [7:0] w_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [15:0] acc_out;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              ovf;

    int total = 0;
    int bad = 0;

    neuron_mac dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .x_in     (x_in),
        .w_in     (w_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .acc_out  (acc_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic signed [7:0] xs [4], input logic signed [7:0] ws [4], input bit gaps);
        for (int i = 0; i < 4; i++) begin
            x_in = xs[i];
            w_in = ws[i];
            in_valid = 1'b1;
            tick();
            if (gaps && i < 3) begin
                in_valid = 1'b0;
                x_in = 8'sd99;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL wait_done: out_valid=%0b after %0d cycles, required 1", out_valid, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        #1;
        total += 5;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0b want 0", ovf); end
        if (acc_out !== 16'h0000) begin bad++; $display("FAIL rst_acc: got %h want 0000", acc_out); end
    endtask

    task automatic test_basic();
        logic signed [7:0] xs [4] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        logic signed [7:0] ws [4] = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
        int n;
        do_start();
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready: got %0b want 1", in_ready); end
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %0b want 1", busy); end
        feed(xs, ws, 1'b0);
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain_valid: got %0b want 0", out_valid); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_drain_ready: got %0b want 0", in_ready); end
        wait_done(n);
        total += 3;
        if (n != 1) begin bad++; $display("FAIL basic_latency: got %0d want 1", n); end
        if (acc_out !== 16'h0046) begin bad++; $display("FAIL basic_acc: got %h want 0046", acc_out); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %0b want 0", ovf); end
        tick();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_release: got %0b want 0", out_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got %0b want 0", busy); end
    endtask

    task automatic test_signs();
        logic signed [7:0] xs [4] = '{-8'sd128, -8'sd128, 8'sd127, -8'sd1};
        logic signed [7:0] ws [4] = '{-8'sd128, 8'sd127, 8'sd1, 8'sd1};
        int n;
        tick();
        do_start();
        feed(xs, ws, 1'b0);
        wait_done(n);
        total += 2;
        if (acc_out !== 16'h00FE) begin bad++; $display("FAIL signs_acc: got %h want 00fe", acc_out); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL signs_ovf: got %0b want 0", ovf); end
        tick();
    endtask

    task automatic test_overflow();
        logic signed [7:0] xs [4] = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        logic signed [15:0] exp_acc;
        int n;
`ifdef NEURON_MAC_SAT_EN
        exp_acc = 16'h7FFF;
`else
        exp_acc = 16'hFC04;
`endif
        tick();
        do_start();
        feed(xs, xs, 1'b0);
        wait_done(n);
        total += 2;
        if (acc_out !== exp_acc) begin bad++; $display("FAIL ovf_acc: got %h want %h", acc_out, exp_acc); end
        if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", ovf); end
        tick();
        tick();
        do_start();
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0b want 0", ovf); end
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_handshake();
        logic signed [7:0] xs [4] = '{8'sd10, -8'sd20, 8'sd30, -8'sd40};
        logic signed [7:0] ws [4] = '{8'sd3, 8'sd3, 8'sd3, 8'sd3};
        int n;
        tick();
        out_ready = 1'b0;
        do_start();
        feed(xs, ws, 1'b1);
        wait_done(n);
        total++;
        if (acc_out !== 16'hFFC4) begin bad++; $display("FAIL hs_acc: got %h want ffc4", acc_out); end
        for (int i = 0; i < 3; i++) begin
            start = (i == 0);
            in_valid = 1'b1;
            tick();
            start = 1'b0;
            in_valid = 1'b0;
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL hs_hold_valid%0d: got %0b want 1", i, out_valid); end
            if (acc_out !== 16'hFFC4) begin bad++; $display("FAIL hs_hold_acc%0d: got %h want ffc4", i, acc_out); end
            if (in_ready !== 1'b0) begin bad++; $display("FAIL hs_hold_ready%0d: got %0b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL hs_release: got %0b want 0", out_valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL hs_idle: got %0b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic signed [7:0] xs [4] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        logic signed [7:0] ws [4] = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
        int n;
        tick();
        do_start();
        for (int i = 0; i < 2; i++) begin
            x_in = xs[i];
            w_in = ws[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (acc_out !== 16'h0005) begin bad++; $display("FAIL mid_pre_acc: got %h want 0005", acc_out); end
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %0b want 0", in_ready); end
        if (acc_out !== 16'h0000) begin bad++; $display("FAIL mid_acc: got %h want 0000", acc_out); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
        tick();
        rst_n = 1'b1;
        do_start();
        feed(xs, ws, 1'b0);
        wait_done(n);
        total += 2;
        if (acc_out !== 16'h0046) begin bad++; $display("FAIL mid_rerun_acc: got %h want 0046", acc_out); end
        if (ovf !== 1'b0) begin bad++; $display("FAIL mid_rerun_ovf: got %0b want 0", ovf); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_handshake();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/neuron_mac.md
# neuron_mac

Streaming signed multiply-accumulate stage for one neuron. Accepts N_INPUTS (activation, weight) byte pairs over a valid/ready handshake, sums their 16-bit products into a 16-bit signed accumulator, and presents the dot product to the downstream bias/round adder. That adder takes a 16-bit signed operand and an 8-bit bias.

## Interface
Parameters:
- N_INPUTS, 4: products per dot product, 1..255.
- DATA_W, 8: activation/weight width, signed.
- ACC_W, 16: accumulator/result width, signed; must be ≥ 2*DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin new dot product; honoured only in IDLE.
- x_in  in  DATA_W  signed activation.
- w_in  in  DATA_W  signed weight.
- in_valid  in  1  x_in/w_in valid.
- in_ready  out  1  stage accepts a pair this cycle.
- acc_out  out  ACC_W  signed dot product, to adder in1.
- out_valid  out  1  acc_out valid.
- out_ready  in  1  downstream consumes acc_out.
- busy  out  1  high in any state other than IDLE.
- ovf  out  1  signed overflow occurred during the current dot product.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE: in_ready=0. On start, clear acc, count and ovf, then go to ACCUM.
- ACCUM: in_ready=1.
  - Each beat where in_valid&&in_ready registers the product p_q = x_in*w_in (full 2*DATA_W signed) and sets p_vld. It also increments count.
  - The accepted beat with count==N_INPUTS-1 moves the FSM to DRAIN. in_ready drops in the following cycle.
- Accumulate path: whenever p_vld, acc <= acc + sign_ext(p_q).
  - Overflow is detected when both operands have the same sign and the result's sign differs. Detection sets ovf, which is sticky until the next start.
- DRAIN: one cycle for the final product to enter acc, then go to DONE.
- DONE: out_valid=1, acc_out=acc. When out_ready is high, go to IDLE and drop out_valid the next cycle.
- start in any state other than IDLE is ignored. in_valid in IDLE, DRAIN or DONE is ignored (no beat).
- acc_out always drives acc. It holds stable from DONE entry until the cycle after the handshake.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, ovf=0, acc_out=0, state=IDLE, count=0, p_vld=0.
- start at cycle t: busy=1 and in_ready=1 at t+1.
- Last pair accepted at cycle k: out_valid=1 at k+2.
- With in_valid held high, throughput is N_INPUTS+2 cycles from the first beat to out_valid. Add 1 cycle for the DONE handshake and 1 cycle back in IDLE before the next start.
- Gaps in in_valid stall count. The product pipeline drains normally.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). No partial result is emitted.

## Configuration
- NEURON_MAC_SAT_EN defined: on overflow, the accumulator clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) according to the operand sign. Further accumulation continues from the clamped value. ovf is still set.
- Undefined: two's-complement wrap. ovf is set.

## Structure
- Package neuron_pkg holds:
  - DATA_W and ACC_W localparams.
  - mac_state_t enum (IDLE, ACCUM, DRAIN, DONE).
  - Shared by the adder and future activation stages.
- Sub-module neuron_mul: registered signed DATA_W×DATA_W multiplier. It carries valid in and out and produces p_q/p_vld.
- The counter, FSM and accumulator stay in neuron_mac.

## Test plan
- Basic: x=1,2,3,4 and w=5,6,7,8, in_valid held high → acc_out=0x0046 (70), out_valid 2 cycles after the 4th beat, ovf=0.
- Signs and extremes: x=-128,-128,127,-1 and w=-128,127,1,1 → 16384-16256+127-1 = 254 (0x00FE), ovf=0.
- Overflow: four pairs of x=127, w=127.
  - Without the macro: acc_out=0xFC04 (-1020), ovf=1.
  - With NEURON_MAC_SAT_EN: acc_out=0x7FFF, ovf=1.
- Handshake:
  - in_valid toggles 1,0,1,0, and out_ready is held low for 3 cycles in DONE.
  - Result must be correct.
  - acc_out and out_valid stay stable until out_ready.
  - A start pulse during ACCUM or DONE is ignored.
- Reset mid-operation: assert rst_n=0 after 2 accepted beats.
  - Outputs go to reset values with no clock edge.
  - After release, a new start with x=1,2,3,4 and w=5,6,7,8 yields 0x0046.
